// File: rtl/seg7_scan_mod20.sv
// Two-digit multiplexed 7-segment driver for a mod-20 count, with a
// wrap indicator that stays lit for a number of refresh ticks after each wrap.
module seg7_scan_mod20 #(
    parameter int REFRESH_DIV = 50000,
    parameter int WRAP_HOLD   = 250
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic [4:0] count_in,
    output logic [6:0] segments,
    output logic [1:0] anodes,
    output logic       wrap_led
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int HW = $clog2(WRAP_HOLD + 1);
    localparam logic [RW-1:0] RCNT_MAX  = RW'(REFRESH_DIV - 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(WRAP_HOLD);

    logic [4:0]    r_val_q;
    logic [4:0]    r_prev_q;
    logic [RW-1:0] r_rcnt;
    logic          r_digit_sel;
    logic [HW-1:0] r_hold;
    logic [6:0]    r_segments;
    logic [1:0]    r_anodes;
    logic          r_wrap_led;

    logic          w_tick;
    logic          w_wrap;
    logic [4:0]    w_units_val;
    logic [6:0]    w_seg_units;
    logic [6:0]    w_seg_tens;

    function automatic logic [6:0] f_enc(input logic [3:0] d);
        case (d)
            4'd0:    f_enc = 7'h40;
            4'd1:    f_enc = 7'h79;
            4'd2:    f_enc = 7'h24;
            4'd3:    f_enc = 7'h30;
            4'd4:    f_enc = 7'h19;
            4'd5:    f_enc = 7'h12;
            4'd6:    f_enc = 7'h02;
            4'd7:    f_enc = 7'h78;
            4'd8:    f_enc = 7'h00;
            4'd9:    f_enc = 7'h10;
            default: f_enc = 7'h7F;
        endcase
    endfunction

    assign w_tick = (r_rcnt == RCNT_MAX);
    // Only the exact 19<->0 transitions count; out-of-range values never match.
    assign w_wrap = ((r_prev_q == 5'd19) && (r_val_q == 5'd0)) ||
                    ((r_prev_q == 5'd0)  && (r_val_q == 5'd19));
    assign w_units_val = r_val_q - 5'd10;

    always_comb begin
        w_seg_units = 7'h7F;
        w_seg_tens  = 7'h7F;
        if (r_val_q < 5'd10) begin
            w_seg_units = f_enc(r_val_q[3:0]);
        end else if (r_val_q < 5'd20) begin
            w_seg_units = f_enc(w_units_val[3:0]);
            w_seg_tens  = 7'h79;
        end else begin
            w_seg_units = 7'h2F;
            w_seg_tens  = 7'h06;
        end
    end

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            r_val_q     <= 5'd0;
            r_prev_q    <= 5'd0;
            r_rcnt      <= '0;
            r_digit_sel <= 1'b0;
        end else begin
            r_val_q  <= count_in;
            r_prev_q <= r_val_q;
            if (w_tick) begin
                r_rcnt      <= '0;
                r_digit_sel <= ~r_digit_sel;
            end else begin
                r_rcnt <= r_rcnt + RW'(1);
            end
        end
    end

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            r_segments <= 7'h7F;
            r_anodes   <= 2'b11;
        end else if (r_digit_sel) begin
            r_segments <= w_seg_tens;
            r_anodes   <= 2'b01;
        end else begin
            r_segments <= w_seg_units;
            r_anodes   <= 2'b10;
        end
    end

    // A wrap reloads the hold count even when it coincides with a tick.
    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            r_hold     <= '0;
            r_wrap_led <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_hold <= HOLD_INIT;
            end else if (w_tick && (r_hold != '0)) begin
                r_hold <= r_hold - HW'(1);
            end
            r_wrap_led <= w_wrap || (r_hold != '0);
        end
    end

    assign segments = r_segments;
    assign anodes   = r_anodes;
    assign wrap_led = r_wrap_led;

endmodule

// File: doc/seg7_scan_mod20.md
SEG7_SCAN_MOD20 -- requirements
Module: seg7_scan_mod20

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clk_50M cycles per digit slot; legal range >=2.
REQ-002 SHALL have parameter WRAP_HOLD, default 250, refresh ticks wrap_led stays high after a wrap; legal range >=1.
REQ-003 SHALL have port clk_50M  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port count_in  input  5  binary count from the upstream mod-20 counter; legal 0..19.
REQ-006 SHALL have port segments  output  7  {g,f,e,d,c,b,a}, active-low, registered.
REQ-007 SHALL have port anodes  output  2  digit enables, active-low; bit0 = units, bit1 = tens; registered.
REQ-008 SHALL have port wrap_led  output  1  high while a wrap indication is active; registered.

Function
REQ-009 SHALL sample count_in into val_q every clock; val_q's value on the previous clock SHALL be held in prev_q.
REQ-010 SHALL run refresh counter rcnt 0..REFRESH_DIV-1; tick SHALL assert for one cycle when rcnt = REFRESH_DIV-1; rcnt then SHALL wrap to 0.
REQ-011 SHALL toggle digit_sel on each tick; digit_sel=0 selects units, 1 selects tens.
REQ-012 SHALL drive anodes = 2'b10 when digit_sel=0, 2'b01 when digit_sel=1; never both low.
REQ-013 SHALL decode val_q 0..9 as tens=0, units=val_q; 10..19 as tens=1, units=val_q-10.
REQ-014 SHALL encode digits (hex, active-low gfedcba): 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10.
REQ-015 SHALL blank the tens digit (segments=7F) when val_q<10.
REQ-016 SHALL, for val_q 20..31, show tens='E' (06) and units='r' (2F); wrap detection SHALL ignore these values.
REQ-017 SHALL register segments/anodes from digit_sel and val_q; count_in change SHALL reach segments 2 clocks later while its digit is selected.
REQ-018 SHALL detect wrap when (prev_q=19 and val_q=0) or (prev_q=0 and val_q=19).
REQ-019 SHALL, on wrap, set wrap_led=1 on the next clock and load hold counter with WRAP_HOLD.
REQ-020 SHALL decrement hold counter on each tick while nonzero; wrap_led SHALL drop on the clock after it reaches 0.
REQ-021 SHALL, on wrap while wrap_led=1, reload hold counter to WRAP_HOLD (retrigger); wrap and tick in same cycle SHALL reload, not decrement.
REQ-022 SHALL make display scanning independent of wrap_led; no blanking of digits during wrap indication.

Reset
REQ-023 SHALL, while reset=1, force val_q=0, prev_q=0, rcnt=0, digit_sel=0, hold counter=0, segments=7F, anodes=2'b11, wrap_led=0.
REQ-024 SHALL, on first clock after reset release with count_in=0, drive anodes=2'b10, segments=40.
REQ-025 SHALL abort any wrap indication and scan position when reset asserts mid-operation; no wrap SHALL be detected from pre-reset history.

Verification
REQ-026 Reset: assert reset mid-scan with wrap_led=1 -> same instant segments=7F, anodes=11, wrap_led=0; after release count_in=0 -> anodes=10, segments=40.
REQ-027 Scan (REFRESH_DIV=4): count_in=7 held -> anodes alternate 10/01 every 4 clocks; units slot 78, tens slot 7F.
REQ-028 Decode: count_in=15 -> units slot 12, tens slot 79; count_in=10 -> units 40, tens 79.
REQ-029 Wrap (WRAP_HOLD=2, REFRESH_DIV=4): count_in 19->0 -> wrap_led=1 one clock after val_q=0, low after 2 further ticks; 0->19 behaves identically; 18->19 no wrap.
REQ-030 Retrigger: second 19->0 wrap while wrap_led=1, coincident with a tick -> hold reloaded to 2, wrap_led stays high 2 ticks from reload.
REQ-031 Out of range: count_in=25 -> tens slot 06, units slot 2F, wrap_led unchanged; 25->0 no wrap.
